// File: rtl/uart_packet_dma_ctrl.sv
// Frame parser and byte-wide memory writer behind the UART receiver.
// Optional trailing checksum byte is enabled by defining PKT_CHECKSUM_EN.
module uart_packet_dma_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         ADDR_W    = 8,
   parameter int         TIMEOUT   = 4000
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_frm_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              pkt_done,
   output logic              pkt_err,
   output logic [7:0]        pkt_len,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BASE = 3'd1,
      ST_LEN  = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4
   } state_t;

   // The counter value seen on the edge that expires is TIMEOUT-1.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   base_r, base_s;
   logic [7:0]          len_r, len_s;
   logic [7:0]          idx_r, idx_s;
   logic [7:0]          sum_r, sum_s;
   logic [15:0]         tmo_r, tmo_s;
   logic                we_s, done_s, err_s, busy_s;
   logic [ADDR_W-1:0]   addr_s;
   logic [7:0]          wdata_s, pkt_len_s;

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_s   = state_r;
      base_s    = base_r;
      len_s     = len_r;
      idx_s     = idx_r;
      sum_s     = sum_r;
      tmo_s     = tmo_r + 16'd1;
      we_s      = 1'b0;
      addr_s    = mem_addr;
      wdata_s   = mem_wdata;
      done_s    = 1'b0;
      err_s     = 1'b0;
      pkt_len_s = pkt_len;

      if (state_r == ST_IDLE) begin
         tmo_s = 16'd0;
         if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_s = ST_BASE;
            sum_s   = 8'd0;
         end else begin
            state_s = ST_IDLE;
         end
      end else if (rx_frm_err) begin
         // Framing error beats a same-cycle byte; the byte is dropped.
         err_s   = 1'b1;
         state_s = ST_IDLE;
         tmo_s   = 16'd0;
      end else if (rx_valid) begin
         tmo_s = 16'd0;
         case (state_r)
            ST_BASE: begin
               base_s  = ADDR_W'(rx_data);
               sum_s   = sum_r + rx_data;
               state_s = ST_LEN;
            end
            ST_LEN: begin
               if (rx_data == 8'd0) begin
                  err_s   = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  len_s     = rx_data;
                  pkt_len_s = rx_data;
                  idx_s     = 8'd0;
                  sum_s     = sum_r + rx_data;
                  state_s   = ST_DATA;
               end
            end
            ST_DATA: begin
               we_s    = 1'b1;
               addr_s  = base_r + ADDR_W'(idx_r);
               wdata_s = rx_data;
               idx_s   = idx_r + 8'd1;
               sum_s   = sum_r + rx_data;
               if (idx_r == (len_r - 8'd1)) begin
`ifdef PKT_CHECKSUM_EN
                  state_s = ST_CSUM;
`else
                  done_s  = 1'b1;
                  state_s = ST_IDLE;
`endif
               end else begin
                  state_s = ST_DATA;
               end
            end
`ifdef PKT_CHECKSUM_EN
            ST_CSUM: begin
               if ((sum_r + rx_data) == 8'h00) begin
                  done_s = 1'b1;
               end else begin
                  err_s  = 1'b1;
               end
               state_s = ST_IDLE;
            end
`endif
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else if (tmo_r == TMO_LAST) begin
         err_s   = 1'b1;
         state_s = ST_IDLE;
         tmo_s   = 16'd0;
      end else begin
         state_s = state_r;
      end

      busy_s = (state_s != ST_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r   <= ST_IDLE;
         base_r    <= '0;
         len_r     <= 8'd0;
         idx_r     <= 8'd0;
         sum_r     <= 8'd0;
         tmo_r     <= 16'd0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         pkt_done  <= 1'b0;
         pkt_err   <= 1'b0;
         pkt_len   <= 8'd0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_s;
         base_r    <= base_s;
         len_r     <= len_s;
         idx_r     <= idx_s;
         sum_r     <= sum_s;
         tmo_r     <= tmo_s;
         mem_we    <= we_s;
         mem_addr  <= addr_s;
         mem_wdata <= wdata_s;
         pkt_done  <= done_s;
         pkt_err   <= err_s;
         pkt_len   <= pkt_len_s;
         busy      <= busy_s;
      end
   end

endmodule
